// File: rtl/axis_uart_rx.sv
// axis_uart_rx -- UART receiver with an AXI-Stream master output.
//
// Purpose: oversamples the asynchronous serial line uart_rx and decodes a frame of
// start bit, 8 data bits (LSB first), one parity bit and one or two stop bits. Each
// received byte is presented on a one-deep AXIS output register with per-byte error
// flags. Framing configuration is shared with the transmit side.
//
// Ports:
//   clk, rst_n        clock; asynchronous active-low reset
//   uart_rx           serial input, idle high, asynchronous to clk
//   maxis_data_o      received byte
//   maxis_tuser_o     [0] parity error, [1] framing error for this byte
//   maxis_tvalid_o    byte valid
//   maxis_tready_i    downstream ready
//   divider           bit period = divider+1 clk (values below 3 act as 3)
//   stop_bit_num      0: one stop bit, 1: two stop bits
//   parity_bit_mode   0: bit=0, 1: bit=1, 2: odd (~^data), 3: even (^data), 4-7: bit=0
//   busy_o            high while a frame is being decoded
//   parity_err_o      1-clk pulse on parity mismatch
//   frame_err_o       1-clk pulse when a stop bit is sampled low
//   overrun_o         1-clk pulse when a completed byte is dropped
module axis_uart_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_rx,
    output logic [7:0]  maxis_data_o,
    output logic [1:0]  maxis_tuser_o,
    output logic        maxis_tvalid_o,
    input  logic        maxis_tready_i,
    input  logic [31:0] divider,
    input  logic        stop_bit_num,
    input  logic [2:0]  parity_bit_mode,
    output logic        busy_o,
    output logic        parity_err_o,
    output logic        frame_err_o,
    output logic        overrun_o
);

    localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5
    } state_t;

    // Expected parity bit for a byte under a given mode.
    function automatic logic exp_parity(input logic [2:0] mode, input logic [7:0] data);
        logic p;
        case (mode)
            3'd0:    p = 1'b0;
            3'd1:    p = 1'b1;
            3'd2:    p = ~^data;
            3'd3:    p = ^data;
            default: p = 1'b0;
        endcase
        return p;
    endfunction

    state_t      state_q, state_d;
    logic [NS-1:0] sync_q, sync_d;
    logic        rx_prev_q, rx_prev_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] div_q, div_d;
    logic        stop2_q, stop2_d;
    logic [2:0]  mode_q, mode_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_err_q, par_err_d;
    logic        frm_err_q, frm_err_d;
    logic [7:0]  data_q, data_d;
    logic [1:0]  tuser_q, tuser_d;
    logic        tvalid_q, tvalid_d;
    logic        perr_q, perr_d;
    logic        ferr_q, ferr_d;
    logic        ovr_q, ovr_d;

    logic        rx_s;
    logic        sample_s;
    logic        finish_s;
    logic        fin_frm_s;
    logic [31:0] div_eff_s;
    logic [31:0] half_s;

    assign rx_s      = sync_q[NS-1];
    assign div_eff_s = (divider < 32'd3) ? 32'd3 : divider;
    // floor((div+1)/2) computed without a carry out of 32 bits, so div=0xFFFF_FFFF is safe.
    assign half_s    = {1'b0, div_eff_s[31:1]} + {31'd0, div_eff_s[0]};
    assign sample_s  = (state_q != IDLE) && (cnt_q == 32'd0);
    assign fin_frm_s = frm_err_q | ~rx_s;

    // Next-state logic: synchronizer, frame decoder FSM and output register.
    always_comb begin
        sync_d    = {sync_q[NS-2:0], uart_rx};
        rx_prev_d = rx_s;
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        stop2_d   = stop2_q;
        mode_d    = mode_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_err_d = par_err_q;
        frm_err_d = frm_err_q;
        data_d    = data_q;
        tuser_d   = tuser_q;
        tvalid_d  = tvalid_q;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
        ovr_d     = 1'b0;
        finish_s  = 1'b0;

        if (state_q == IDLE) begin
            // Only a genuine 1->0 transition starts a frame; a line stuck low does not.
            if (rx_prev_q && !rx_s) begin
                state_d   = START;
                div_d     = div_eff_s;
                cnt_d     = half_s - 32'd1;
                stop2_d   = stop_bit_num;
                mode_d    = parity_bit_mode;
                bit_cnt_d = 3'd0;
                par_err_d = 1'b0;
                frm_err_d = 1'b0;
            end else begin
                cnt_d = cnt_q;
            end
        end else if (!sample_s) begin
            cnt_d = cnt_q - 32'd1;
        end else begin
            cnt_d = div_q;
            case (state_q)
                START: begin
                    state_d = rx_s ? IDLE : DATA;
                end
                DATA: begin
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end else begin
                        state_d = DATA;
                    end
                end
                PARITY: begin
                    par_err_d = (rx_s != exp_parity(mode_q, shift_q));
                    state_d   = STOP1;
                end
                STOP1: begin
                    if (stop2_q) begin
                        frm_err_d = fin_frm_s;
                        state_d   = STOP2;
                    end else begin
                        finish_s = 1'b1;
                        state_d  = IDLE;
                    end
                end
                STOP2: begin
                    finish_s = 1'b1;
                    state_d  = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // A completed byte loads unless the held byte is still waiting for a handshake.
        if (finish_s) begin
            perr_d = par_err_q;
            ferr_d = fin_frm_s;
            if (!tvalid_q || maxis_tready_i) begin
                data_d   = shift_q;
                tuser_d  = {fin_frm_s, par_err_q};
                tvalid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (tvalid_q && maxis_tready_i) begin
            tvalid_d = 1'b0;
        end else begin
            tvalid_d = tvalid_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sync_q    <= {NS{1'b1}};
            rx_prev_q <= 1'b1;
            cnt_q     <= 32'd0;
            div_q     <= 32'd3;
            stop2_q   <= 1'b0;
            mode_q    <= 3'd0;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'd0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            data_q    <= 8'd0;
            tuser_q   <= 2'd0;
            tvalid_q  <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            rx_prev_q <= rx_prev_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            stop2_q   <= stop2_d;
            mode_q    <= mode_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_err_q <= par_err_d;
            frm_err_q <= frm_err_d;
            data_q    <= data_d;
            tuser_q   <= tuser_d;
            tvalid_q  <= tvalid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    assign maxis_data_o   = data_q;
    assign maxis_tuser_o  = tuser_q;
    assign maxis_tvalid_o = tvalid_q;
    assign busy_o         = (state_q != IDLE);
    assign parity_err_o   = perr_q;
    assign frame_err_o    = ferr_q;
    assign overrun_o      = ovr_q;

endmodule

// File: tb/tb_axis_uart_rx.sv
// Directed testbench for axis_uart_rx: a bench-side serial driver builds frames,
// a negedge monitor records accepted beats and error pulses, and the main
// sequence checks them against hand-computed values.
module tb_axis_uart_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        uart_rx = 1'b1;
    logic [7:0]  maxis_data_o;
    logic [1:0]  maxis_tuser_o;
    logic        maxis_tvalid_o;
    logic        maxis_tready_i = 1'b1;
    logic [31:0] divider = 32'd15;
    logic        stop_bit_num = 1'b0;
    logic [2:0]  parity_bit_mode = 3'd3;
    logic        busy_o;
    logic        parity_err_o;
    logic        frame_err_o;
    logic        overrun_o;

    int tests = 0;
    int fails = 0;
    int perr_cnt = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    logic [9:0] beats[$];

    axis_uart_rx #(.SYNC_STAGES(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .uart_rx        (uart_rx),
        .maxis_data_o   (maxis_data_o),
        .maxis_tuser_o  (maxis_tuser_o),
        .maxis_tvalid_o (maxis_tvalid_o),
        .maxis_tready_i (maxis_tready_i),
        .divider        (divider),
        .stop_bit_num   (stop_bit_num),
        .parity_bit_mode(parity_bit_mode),
        .busy_o         (busy_o),
        .parity_err_o   (parity_err_o),
        .frame_err_o    (frame_err_o),
        .overrun_o      (overrun_o)
    );

    always #5 clk = ~clk;

    // Monitor: record handshaken beats and count error pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (maxis_tvalid_o && maxis_tready_i) beats.push_back({maxis_tuser_o, maxis_data_o});
            if (parity_err_o) perr_cnt++;
            if (frame_err_o) ferr_cnt++;
            if (overrun_o) ovr_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic [7:0] d, input logic [1:0] u);
        logic [9:0] b;
        if (beats.size() > 0) b = beats.pop_front();
        else b = 'x;
        chk(tag, {22'd0, b}, {22'd0, u, d});
    endtask

    task automatic clocks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        uart_rx = b;
        clocks(int'(divider) + 1);
    endtask

    // Full frame: start, 8 data LSB first, parity, stop1, optional stop2.
    task automatic send(input logic [7:0] d, input logic par, input logic s1, input logic s2,
                        input logic two);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(par);
        drive_bit(s1);
        if (two) drive_bit(s2);
        uart_rx = 1'b1;
    endtask

    task automatic clear_counts();
        beats.delete();
        perr_cnt = 0;
        ferr_cnt = 0;
        ovr_cnt = 0;
    endtask

    initial begin
        clocks(3);
        chk("reset_tvalid", {31'd0, maxis_tvalid_o}, 32'd0);
        chk("reset_data", {24'd0, maxis_data_o}, 32'd0);
        chk("reset_busy", {31'd0, busy_o}, 32'd0);
        rst_n = 1'b1;
        clocks(5);

        // 1: even parity, 0xA5 has four ones -> parity 0, clean byte.
        send(8'hA5, 1'b0, 1'b1, 1'b1, 1'b0);
        clocks(40);
        chk("t1_count", beats.size(), 32'd1);
        chk_beat("t1_beat", 8'hA5, 2'b00);
        chk("t1_perr", perr_cnt, 32'd0);
        chk("t1_ferr", ferr_cnt, 32'd0);
        clear_counts();

        // 2: odd parity on 0x01 expects 0; send 1 -> parity error.
        parity_bit_mode = 3'd2;
        send(8'h01, 1'b1, 1'b1, 1'b1, 1'b0);
        clocks(40);
        chk_beat("t2_beat", 8'h01, 2'b01);
        chk("t2_perr", perr_cnt, 32'd1);
        chk("t2_ferr", ferr_cnt, 32'd0);
        clear_counts();

        // 3: two stop bits, second one low; line then held low.
        stop_bit_num = 1'b1;
        send(8'h3C, 1'b1, 1'b1, 1'b0, 1'b1);
        uart_rx = 1'b0;
        clocks(80);
        chk_beat("t3_beat", 8'h3C, 2'b10);
        chk("t3_ferr", ferr_cnt, 32'd1);
        chk("t3_perr", perr_cnt, 32'd0);
        chk("t3_held_low_busy", {31'd0, busy_o}, 32'd0);
        chk("t3_held_low_nobeat", beats.size(), 32'd0);
        uart_rx = 1'b1;
        clocks(40);
        chk("t3_after_release", beats.size(), 32'd0);
        clear_counts();

        // 4: 5-clk glitch -> false start.
        stop_bit_num = 1'b0;
        uart_rx = 1'b0;
        clocks(5);
        uart_rx = 1'b1;
        chk("t4_busy_high", {31'd0, busy_o}, 32'd1);
        clocks(30);
        chk("t4_busy_low", {31'd0, busy_o}, 32'd0);
        chk("t4_nobeat", beats.size(), 32'd0);
        chk("t4_nopulse", perr_cnt + ferr_cnt + ovr_cnt, 32'd0);
        clear_counts();

        // 5: overrun with tready low (odd parity: 0x11, 0x22 both -> 1).
        maxis_tready_i = 1'b0;
        send(8'h11, 1'b1, 1'b1, 1'b1, 1'b0);
        send(8'h22, 1'b1, 1'b1, 1'b1, 1'b0);
        clocks(40);
        chk("t5_tvalid_held", {31'd0, maxis_tvalid_o}, 32'd1);
        chk("t5_data_held", {24'd0, maxis_data_o}, 32'h11);
        chk("t5_overrun", ovr_cnt, 32'd1);
        maxis_tready_i = 1'b1;
        clocks(3);
        chk("t5_tvalid_drop", {31'd0, maxis_tvalid_o}, 32'd0);
        chk("t5_count", beats.size(), 32'd1);
        chk_beat("t5_beat", 8'h11, 2'b00);
        clear_counts();

        // 6: div=7, two stop bits, odd parity, back-to-back frames.
        divider = 32'd7;
        stop_bit_num = 1'b1;
        send(8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
        send(8'hFF, 1'b1, 1'b1, 1'b1, 1'b1);
        send(8'h55, 1'b1, 1'b1, 1'b1, 1'b1);
        clocks(30);
        chk("t6_count", beats.size(), 32'd3);
        chk_beat("t6_b0", 8'h00, 2'b00);
        chk_beat("t6_b1", 8'hFF, 2'b00);
        chk_beat("t6_b2", 8'h55, 2'b00);
        chk("t6_nopulse", perr_cnt + ferr_cnt + ovr_cnt, 32'd0);
        clear_counts();

        // Reset mid-frame with a held byte pending.
        maxis_tready_i = 1'b0;
        send(8'h5A, 1'b1, 1'b1, 1'b1, 1'b1);
        clocks(20);
        chk("t6_hold_before_rst", {31'd0, maxis_tvalid_o}, 32'd1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        rst_n = 1'b0;
        clocks(2);
        chk("t6_rst_tvalid", {31'd0, maxis_tvalid_o}, 32'd0);
        chk("t6_rst_busy", {31'd0, busy_o}, 32'd0);
        chk("t6_rst_data", {24'd0, maxis_data_o}, 32'd0);
        uart_rx = 1'b1;
        maxis_tready_i = 1'b1;
        clocks(3);
        rst_n = 1'b1;
        clocks(5);
        clear_counts();
        send(8'h81, 1'b1, 1'b1, 1'b1, 1'b1);
        clocks(30);
        chk("t6_post_count", beats.size(), 32'd1);
        chk_beat("t6_post_beat", 8'h81, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
